// File: rtl/alu_bist_pkg.sv
// Shared definitions for the alu self-test engine: opcodes, FSM encoding and the
// golden alu model used by both the checker and the alu bench.
package alu_bist_pkg;

    localparam int MAX_W = 16;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Evaluated at full 16-bit width; callers keep the low WIDTH bits, which gives
    // the modulo-2**WIDTH result for ADD/SUB.
    function automatic logic [MAX_W-1:0] alu_golden(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input logic [2:0]       op);
        logic [MAX_W-1:0] r;
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// 32-bit Fibonacci LFSR (taps 32,22,2,1) supplying operand pairs to the alu BIST.
// A takes the low WIDTH bits of the state, B the high WIDTH bits.
module alu_bist_lfsr #(
    parameter int          WIDTH = 8,
    parameter logic [31:0] SEED  = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             step_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    // An all-zero state would lock up the register.
    localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic        fb;

    assign fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            lfsr_d = SEED_EFF;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[30:0], fb};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign a_o = lfsr_q[WIDTH-1:0];
    assign b_o = lfsr_q[31:32-WIDTH];

endmodule

// File: rtl/alu_bist_ctrl.sv
// Alu self-test controller: drives LFSR operands and cycling opcodes into the alu
// and checks each result against the golden model. ALU_BIST_FAILCAP_EN adds
// capture of the first failing vector on fail_*.
//   state    | meaning
//   IDLE     | waiting for start after reset
//   DRIVE    | register next operands/opcode onto the alu inputs
//   CHECK    | compare alu_result, update counters, step LFSR
//   DONE     | run finished, results held until next start
module alu_bist_ctrl
    import alu_bist_pkg::*;
#(
    parameter int          WIDTH = 8,
    parameter int          CNT_W = 16,
    parameter int          ERR_W = 8,
    parameter logic [31:0] SEED  = 32'hACE1_2468
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [ERR_W-1:0] err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b,
    output logic [2:0]       fail_op,
    output logic [WIDTH-1:0] fail_res
);

    localparam logic [MAX_W-1:0] WMASK = MAX_W'((32'h1 << WIDTH) - 32'h1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic [CNT_W-1:0] vec_q, vec_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic             lfsr_load;
    logic             lfsr_step;
    logic [WIDTH-1:0] lfsr_a;
    logic [WIDTH-1:0] lfsr_b;
    logic [CNT_W-1:0] vec_inc;
    logic [MAX_W-1:0] golden;
    logic             mismatch;
    logic             start_accept;

    alu_bist_lfsr #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .step_i (lfsr_step),
        .a_o    (lfsr_a),
        .b_o    (lfsr_b)
    );

    assign golden       = alu_golden(MAX_W'(alu_a_q), MAX_W'(alu_b_q), alu_op_q);
    assign mismatch     = ((golden ^ MAX_W'(alu_result)) & WMASK) != '0;
    assign vec_inc      = vec_q + CNT_W'(1);
    assign start_accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        op_d      = op_q;
        num_d     = num_q;
        vec_d     = vec_q;
        err_d     = err_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_accept) begin
                    num_d     = num_vectors;
                    vec_d     = '0;
                    err_d     = '0;
                    op_d      = OP_ADD;
                    lfsr_load = 1'b1;
                    state_d   = (num_vectors != '0) ? ST_DRIVE : ST_DONE;
                end
            end
            ST_DRIVE: begin
                alu_a_d  = lfsr_a;
                alu_b_d  = lfsr_b;
                alu_op_d = op_q;
                state_d  = ST_CHECK;
            end
            ST_CHECK: begin
                if (vec_q != '1) begin
                    vec_d = vec_inc;
                end
                if (mismatch && (err_q != '1)) begin
                    err_d = err_q + ERR_W'(1);
                end
                lfsr_step = 1'b1;
                op_d      = (op_q == OP_XOR) ? OP_ADD : 3'(op_q + 3'd1);
                state_d   = (vec_inc == num_q) ? ST_DONE : ST_DRIVE;
            end
            default: state_d = ST_IDLE;
        endcase

        // done/pass lag the DONE state by one cycle and drop on the start edge.
        done_d = (state_q == ST_DONE) && !start;
        pass_d = done_d && (err_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            op_q     <= OP_ADD;
            num_q    <= '0;
            vec_q    <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            op_q     <= op_d;
            num_q    <= num_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_CHECK);
    assign done       = done_q;
    assign pass       = pass_q;
    assign vec_count  = vec_q;
    assign err_count  = err_q;

`ifdef ALU_BIST_FAILCAP_EN
    logic [WIDTH-1:0] fail_a_q, fail_b_q, fail_res_q;
    logic [2:0]       fail_op_q;
    logic             first_fail;

    // err_count is cleared on start, so zero marks the first mismatch of a run.
    assign first_fail = (state_q == ST_CHECK) && mismatch && (err_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_op_q  <= '0;
            fail_res_q <= '0;
        end else if (start_accept) begin
            fail_a_q   <= '0;
            fail_b_q   <= '0;
            fail_op_q  <= '0;
            fail_res_q <= '0;
        end else if (first_fail) begin
            fail_a_q   <= alu_a_q;
            fail_b_q   <= alu_b_q;
            fail_op_q  <= alu_op_q;
            fail_res_q <= alu_result;
        end
    end

    assign fail_a   = fail_a_q;
    assign fail_b   = fail_b_q;
    assign fail_op  = fail_op_q;
    assign fail_res = fail_res_q;
`else
    assign fail_a   = '0;
    assign fail_b   = '0;
    assign fail_op  = '0;
    assign fail_res = '0;
`endif

endmodule
